// File: rtl/dfe_pam4_slicer.sv
// PAM-4 decision-feedback equalizer: subtract weighted past decisions, slice, register one cycle later.
// Optional sign-sign LMS tap adaptation when DFE_ADAPT_EN is defined; no backpressure.
module dfe_pam4_slicer #(
  parameter int SIGNAL_RESOLUTION = 8,
  parameter int SYMBOL_SEPERATION = 56,
  parameter int DFE_TAPS          = 3,
  parameter int TAP_RESOLUTION    = 8,
  parameter int TAP_FRAC          = 6,
  parameter int ADAPT_DECIM       = 0,
  localparam int AW = (DFE_TAPS > 1) ? $clog2(DFE_TAPS) : 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic signed [SIGNAL_RESOLUTION-1:0]        signal_in,
  input  logic                                       signal_in_valid,
  input  logic                                       tap_wr_en,
  input  logic [AW-1:0]                              tap_wr_addr,
  input  logic signed [TAP_RESOLUTION-1:0]           tap_wr_data,
  input  logic                                       adapt_freeze,
  output logic [1:0]                                 symbol_out,
  output logic                                       symbol_out_valid,
  output logic signed [SIGNAL_RESOLUTION-1:0]        eq_out,
  output logic [DFE_TAPS*TAP_RESOLUTION-1:0]         tap_out
);
  localparam int SR   = SIGNAL_RESOLUTION;
  localparam int TR   = TAP_RESOLUTION;
  localparam int PW   = TR + SR;
  localparam int SW   = PW + $clog2(DFE_TAPS) + 1;
  localparam int EW   = SW + 1;
  localparam int CW   = $clog2(DFE_TAPS + 1);
  localparam int SEP  = SYMBOL_SEPERATION;
  localparam int L_LO = SEP / 2;
  localparam int L_HI = (3 * SEP) / 2;
  localparam logic signed [EW-1:0] EQ_MAX = EW'((2 ** (SR - 1)) - 1);
  localparam logic signed [EW-1:0] EQ_MIN = EW'(-(2 ** (SR - 1)));

  typedef enum logic {WARMUP, RUN} state_t;

  logic signed [TR-1:0] taps [DFE_TAPS];
  logic signed [SR-1:0] hist [DFE_TAPS];
  logic signed [PW-1:0] prod [DFE_TAPS];
  logic signed [SW-1:0] fb;
  logic signed [SW-1:0] fb_shr;
  logic signed [EW-1:0] eq_full;
  logic signed [SR-1:0] eq;
  logic signed [SR-1:0] lvl;
  logic [1:0]           sym;
  state_t               state, state_nxt;
  logic [CW-1:0]        warm_cnt, warm_cnt_nxt;

  function automatic logic signed [SR-1:0] sym_level(input logic [1:0] s);
    case (s)
      2'd0:    sym_level = SR'(-L_HI);
      2'd1:    sym_level = SR'(-L_LO);
      2'd2:    sym_level = SR'(L_LO);
      default: sym_level = SR'(L_HI);
    endcase
  endfunction

  // Feedback loop: purely combinational from the registered history to the next decision.
  always_comb begin
    fb = '0;
    for (int i = 0; i < DFE_TAPS; i++) begin
      prod[i] = PW'(taps[i]) * PW'(hist[i]);
      fb      = fb + SW'(prod[i]);
    end
    fb_shr  = fb >>> TAP_FRAC;
    eq_full = EW'(signal_in) - EW'(fb_shr);
    if (eq_full > EQ_MAX)      eq = {1'b0, {(SR-1){1'b1}}};
    else if (eq_full < EQ_MIN) eq = {1'b1, {(SR-1){1'b0}}};
    else                       eq = eq_full[SR-1:0];
    if (int'(eq) >= SEP)       sym = 2'd3;
    else if (int'(eq) >= 0)    sym = 2'd2;
    else if (int'(eq) >= -SEP) sym = 2'd1;
    else                       sym = 2'd0;
    lvl = sym_level(sym);
  end

  always_comb begin
    tap_out = '0;
    for (int i = 0; i < DFE_TAPS; i++) tap_out[i*TR +: TR] = taps[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= WARMUP;
      warm_cnt <= '0;
    end else begin
      state    <= state_nxt;
      warm_cnt <= warm_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    warm_cnt_nxt = warm_cnt;
    if (state == WARMUP && signal_in_valid) begin
      warm_cnt_nxt = warm_cnt + CW'(1);
      if (warm_cnt_nxt == CW'(DFE_TAPS)) state_nxt = RUN;
    end
  end

`ifdef DFE_ADAPT_EN
  localparam int DW = (ADAPT_DECIM > 0) ? ADAPT_DECIM : 1;
  localparam logic signed [TR-1:0] TAP_MAX = {1'b0, {(TR-1){1'b1}}};
  localparam logic signed [TR-1:0] TAP_MIN = {1'b1, {(TR-1){1'b0}}};

  logic [DW-1:0]        dcnt;
  logic                 adapt_go;
  logic signed [SR:0]   err;
  logic signed [TR-1:0] taps_adapt [DFE_TAPS];

  assign err      = {eq[SR-1], eq} - {lvl[SR-1], lvl};
  assign adapt_go = signal_in_valid && (state == RUN) && !adapt_freeze &&
                    ((ADAPT_DECIM == 0) || (dcnt == {DW{1'b1}}));

  // Sign-sign step: move each tap toward decorrelating the error from its decision.
  always_comb begin
    for (int i = 0; i < DFE_TAPS; i++) begin
      taps_adapt[i] = taps[i];
      if (adapt_go && err != '0 && hist[i] != '0) begin
        if (err[SR] == hist[i][SR-1]) begin
          if (taps[i] != TAP_MAX) taps_adapt[i] = taps[i] + TR'(1);
        end else begin
          if (taps[i] != TAP_MIN) taps_adapt[i] = taps[i] - TR'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                  dcnt <= '0;
    else if (signal_in_valid) dcnt <= dcnt + DW'(1);
  end
`else
  logic unused_freeze;
  assign unused_freeze = adapt_freeze;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      symbol_out       <= '0;
      eq_out           <= '0;
      symbol_out_valid <= 1'b0;
      for (int i = 0; i < DFE_TAPS; i++) begin
        taps[i] <= '0;
        hist[i] <= '0;
      end
    end else begin
      symbol_out_valid <= signal_in_valid;
      if (signal_in_valid) begin
        symbol_out <= sym;
        eq_out     <= eq;
        hist[0]    <= lvl;
        for (int i = 1; i < DFE_TAPS; i++) hist[i] <= hist[i-1];
      end
      // Host write to a tap takes priority over adaptation of that same tap.
      for (int i = 0; i < DFE_TAPS; i++) begin
        if (tap_wr_en && tap_wr_addr == AW'(i)) taps[i] <= tap_wr_data;
`ifdef DFE_ADAPT_EN
        else taps[i] <= taps_adapt[i];
`endif
      end
    end
  end
endmodule

// File: tb/tb_dfe_pam4_slicer.sv
// Self-checking bench for dfe_pam4_slicer: scoreboarded slicer, feedback, saturation, gaps, reset, adaptation.
module tb_dfe_pam4_slicer;
  logic              clk = 1'b0;
  logic              rst;
  logic signed [7:0] signal_in;
  logic              signal_in_valid;
  logic              tap_wr_en;
  logic [1:0]        tap_wr_addr;
  logic signed [7:0] tap_wr_data;
  logic              adapt_freeze;
  logic [1:0]        symbol_out;
  logic              symbol_out_valid;
  logic signed [7:0] eq_out;
  logic [23:0]       tap_out;

  int checks = 0;
  int passed = 0;
  int q_sym[$];
  int q_eq[$];

  dfe_pam4_slicer dut (
    .clk(clk), .rst(rst), .signal_in(signal_in), .signal_in_valid(signal_in_valid),
    .tap_wr_en(tap_wr_en), .tap_wr_addr(tap_wr_addr), .tap_wr_data(tap_wr_data),
    .adapt_freeze(adapt_freeze), .symbol_out(symbol_out), .symbol_out_valid(symbol_out_valid),
    .eq_out(eq_out), .tap_out(tap_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; signal_in_valid = 1'b0; tap_wr_en = 1'b0;
    tick();
    rst = 1'b0;
    q_sym.delete();
    q_eq.delete();
  endtask

  task automatic write_tap(input int addr, input int data);
    tap_wr_en = 1'b1; tap_wr_addr = 2'(addr); tap_wr_data = 8'(data);
    tick();
    tap_wr_en = 1'b0;
  endtask

  task automatic test_reset();
    write_tap(0, 32);
    signal_in = 8'sd84; signal_in_valid = 1'b1;
    tick();
    signal_in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (symbol_out !== 2'd0) $display("FAIL reset_sym: got %0d want 0", symbol_out); else passed++;
    checks++; if (eq_out !== 8'sd0) $display("FAIL reset_eq: got %0d want 0", eq_out); else passed++;
    checks++; if (symbol_out_valid !== 1'b0) $display("FAIL reset_vld: got %b want 0", symbol_out_valid); else passed++;
    checks++; if (tap_out !== 24'h0) $display("FAIL reset_taps: got %h want 000000", tap_out); else passed++;
  endtask

  task automatic test_slicer_levels();
    int xin[8] = '{84, 28, -28, -84, 0, 56, -56, -57};
    int esy[8] = '{3, 2, 1, 0, 2, 3, 1, 0};
    int es, ee;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      signal_in_valid = (i < 8);
      if (i < 8) begin
        signal_in = 8'(xin[i]);
        q_sym.push_back(esy[i]);
        q_eq.push_back(xin[i]);
      end
      tick();
      checks++;
      if (symbol_out_valid !== (i < 8)) $display("FAIL levels_vld[%0d]: got %b want %b", i, symbol_out_valid, (i < 8));
      else passed++;
      if (symbol_out_valid === 1'b1 && q_sym.size() > 0) begin
        es = q_sym.pop_front(); ee = q_eq.pop_front();
        checks++; if (symbol_out !== 2'(es)) $display("FAIL levels_sym[%0d]: got %0d want %0d", i, symbol_out, es); else passed++;
        checks++; if (eq_out !== 8'(ee)) $display("FAIL levels_eq[%0d]: got %0d want %0d", i, eq_out, ee); else passed++;
      end
    end
    checks++; if (eq_out !== -8'sd57) $display("FAIL levels_hold: got %0d want -57", eq_out); else passed++;
  endtask

  // Second sample is written together with tap0=0: it must still see the old tap.
  task automatic test_feedback();
    int xin[3] = '{84, 70, 70};
    int wr[3]  = '{0, 1, 0};
    int esy[3] = '{3, 2, 3};
    int eeq[3] = '{84, 28, 70};
    int es, ee;
    do_reset();
    write_tap(0, 32);
    for (int i = 0; i < 3; i++) begin
      signal_in = 8'(xin[i]); signal_in_valid = 1'b1;
      tap_wr_en = (wr[i] != 0); tap_wr_addr = 2'd0; tap_wr_data = 8'sd0;
      q_sym.push_back(esy[i]); q_eq.push_back(eeq[i]);
      tick();
      tap_wr_en = 1'b0;
      checks++;
      if (symbol_out_valid !== 1'b1 || q_sym.size() == 0) $display("FAIL fb_vld[%0d]: got %b want 1", i, symbol_out_valid);
      else begin
        passed++;
        es = q_sym.pop_front(); ee = q_eq.pop_front();
        checks++; if (symbol_out !== 2'(es)) $display("FAIL fb_sym[%0d]: got %0d want %0d", i, symbol_out, es); else passed++;
        checks++; if (eq_out !== 8'(ee)) $display("FAIL fb_eq[%0d]: got %0d want %0d", i, eq_out, ee); else passed++;
      end
    end
    signal_in_valid = 1'b0;
    checks++; if (tap_out !== 24'h0) $display("FAIL fb_tapwr: got %h want 000000", tap_out); else passed++;
  endtask

  task automatic test_saturation();
    int xin[2] = '{84, 127};
    int es, ee;
    do_reset();
    write_tap(0, -64);
    for (int i = 0; i < 2; i++) begin
      signal_in = 8'(xin[i]); signal_in_valid = 1'b1;
      q_sym.push_back(3); q_eq.push_back(i == 0 ? 84 : 127);
      tick();
      if (symbol_out_valid === 1'b1 && q_sym.size() > 0) begin
        es = q_sym.pop_front(); ee = q_eq.pop_front();
        checks++; if (symbol_out !== 2'(es)) $display("FAIL sat_sym[%0d]: got %0d want %0d", i, symbol_out, es); else passed++;
        checks++; if (eq_out !== 8'(ee)) $display("FAIL sat_eq[%0d]: got %0d want %0d", i, eq_out, ee); else passed++;
      end else begin
        checks++; $display("FAIL sat_vld[%0d]: got %b want 1", i, symbol_out_valid);
      end
    end
    signal_in_valid = 1'b0;
  endtask

  task automatic test_valid_gaps();
    int vld[4] = '{1, 0, 0, 1};
    int xin[4] = '{84, -100, -100, 70};
    int es, ee;
    do_reset();
    write_tap(0, 32);
    for (int i = 0; i < 4; i++) begin
      signal_in = 8'(xin[i]); signal_in_valid = (vld[i] != 0);
      if (vld[i] != 0) begin
        q_sym.push_back(i == 0 ? 3 : 2); q_eq.push_back(i == 0 ? 84 : 28);
      end
      tick();
      checks++;
      if (symbol_out_valid !== (vld[i] != 0)) $display("FAIL gap_vld[%0d]: got %b want %0d", i, symbol_out_valid, vld[i]);
      else passed++;
      if (symbol_out_valid === 1'b1 && q_sym.size() > 0) begin
        es = q_sym.pop_front(); ee = q_eq.pop_front();
        checks++; if (symbol_out !== 2'(es)) $display("FAIL gap_sym[%0d]: got %0d want %0d", i, symbol_out, es); else passed++;
        checks++; if (eq_out !== 8'(ee)) $display("FAIL gap_eq[%0d]: got %0d want %0d", i, eq_out, ee); else passed++;
      end else if (vld[i] == 0) begin
        checks++; if (eq_out !== 8'sd84) $display("FAIL gap_hold[%0d]: got %0d want 84", i, eq_out); else passed++;
      end
    end
    signal_in_valid = 1'b0;
    write_tap(3, 8'h55);
    checks++; if (tap_out !== 24'h000020) $display("FAIL bad_addr: got %h want 000020", tap_out); else passed++;
  endtask

  task automatic test_midstream_reset();
    do_reset();
    write_tap(0, 32);
    signal_in = 8'sd84; signal_in_valid = 1'b1;
    tick();
    checks++; if (eq_out !== 8'sd84) $display("FAIL mrst_pre: got %0d want 84", eq_out); else passed++;
    rst = 1'b1; signal_in = 8'sd70; tap_wr_en = 1'b1; tap_wr_addr = 2'd1; tap_wr_data = 8'sd5;
    tick();
    rst = 1'b0; tap_wr_en = 1'b0; signal_in_valid = 1'b0;
    checks++; if (symbol_out_valid !== 1'b0) $display("FAIL mrst_vld: got %b want 0", symbol_out_valid); else passed++;
    checks++; if (symbol_out !== 2'd0 || eq_out !== 8'sd0) $display("FAIL mrst_out: got %0d/%0d want 0/0", symbol_out, eq_out); else passed++;
    checks++; if (tap_out !== 24'h0) $display("FAIL mrst_taps: got %h want 000000", tap_out); else passed++;
    write_tap(0, 32);
    signal_in = 8'sd70; signal_in_valid = 1'b1;
    tick();
    signal_in_valid = 1'b0;
    checks++;
    if (symbol_out_valid !== 1'b1 || symbol_out !== 2'd3 || eq_out !== 8'sd70)
      $display("FAIL mrst_first: got v%b s%0d e%0d want v1 s3 e70", symbol_out_valid, symbol_out, eq_out);
    else passed++;
  endtask

`ifdef DFE_ADAPT_EN
  task automatic test_adaptation();
    int lv[4] = '{-84, -28, 28, 84};
    int prev = 0;
    int s, errs;
    logic [23:0] held;
    do_reset();
    adapt_freeze = 1'b0;
    errs = 0;
    for (int k = 0; k < 2200; k++) begin
      if (k == 2000) begin
        checks++; if ($signed(tap_out[7:0]) < 14 || $signed(tap_out[7:0]) > 18)
          $display("FAIL adapt_tap0: got %0d want 14..18", $signed(tap_out[7:0])); else passed++;
        checks++; if ($signed(tap_out[15:8]) < -2 || $signed(tap_out[15:8]) > 2)
          $display("FAIL adapt_tap1: got %0d want -2..2", $signed(tap_out[15:8])); else passed++;
        checks++; if ($signed(tap_out[23:16]) < -2 || $signed(tap_out[23:16]) > 2)
          $display("FAIL adapt_tap2: got %0d want -2..2", $signed(tap_out[23:16])); else passed++;
        adapt_freeze = 1'b1;
        held = tap_out;
      end
      s = $urandom_range(0, 3);
      signal_in = 8'(lv[s] + prev / 4); signal_in_valid = 1'b1;
      prev = lv[s];
      q_sym.push_back(s);
      tick();
      if (symbol_out_valid !== 1'b1 || q_sym.size() == 0 || symbol_out !== 2'(q_sym.pop_front())) errs++;
    end
    signal_in_valid = 1'b0;
    checks++; if (tap_out !== held) $display("FAIL adapt_freeze: got %h want %h", tap_out, held); else passed++;
    checks++; if (errs != 0) $display("FAIL adapt_decisions: got %0d errors want 0", errs); else passed++;
  endtask
`endif

  initial begin
    rst = 1'b1; signal_in = '0; signal_in_valid = 1'b0; tap_wr_en = 1'b0;
    tap_wr_addr = '0; tap_wr_data = '0; adapt_freeze = 1'b1;
    tick();
    rst = 1'b0;
    test_reset();
    test_slicer_levels();
    test_feedback();
    test_saturation();
    test_valid_gaps();
    test_midstream_reset();
`ifdef DFE_ADAPT_EN
    test_adaptation();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/dfe_pam4_slicer.md
# dfe_pam4_slicer

Receive-side decision-feedback equalizer and PAM-4 slicer. It sits directly downstream of the ISI channel model and consumes that stage's `signal_out` / `signal_out_valid` sample stream. Each valid sample has the weighted sum of previous decisions subtracted, is sliced to a PAM-4 symbol, and is emitted one cycle later. Tap coefficients are programmable; sign-sign LMS tap adaptation is an optional compile-time feature.

## Interface
Parameters:
- `SIGNAL_RESOLUTION`, 8: bit width of the input and equalized samples.
- `SYMBOL_SEPERATION`, 56: spacing between PAM-4 levels.
  - Levels are ±SEP/2 and ±3·SEP/2.
  - Thresholds are -SEP, 0 and +SEP.
- `DFE_TAPS`, 3: number of post-cursor taps, ≥1.
- `TAP_RESOLUTION`, 8: signed tap coefficient width.
- `TAP_FRAC`, 6: fractional bits of a tap, so 64 represents 1.0.
- `ADAPT_DECIM`, 0: adaptation updates once every 2^ADAPT_DECIM valid samples.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `signal_in`  in  SIGNAL_RESOLUTION  signed sample from the channel.
- `signal_in_valid`  in  1  qualifies `signal_in`.
- `tap_wr_en`  in  1  tap write strobe.
- `tap_wr_addr`  in  $clog2(DFE_TAPS) (min 1)  index of the tap to write.
- `tap_wr_data`  in  TAP_RESOLUTION  signed coefficient to write.
- `adapt_freeze`  in  1  holds taps during adaptation; ignored without the macro.
- `symbol_out`  out  2  decided symbol, 0..3.
- `symbol_out_valid`  out  1  qualifies `symbol_out` and `eq_out`.
- `eq_out`  out  SIGNAL_RESOLUTION  signed equalized sample, after saturation.
- `tap_out`  out  DFE_TAPS·TAP_RESOLUTION  packed tap coefficients; tap 0 occupies the LSBs.

## Operation
Decision history:
- `d[0..DFE_TAPS-1]` hold signed level values, not symbols.
- `d[0]` is the decision for the previous valid sample.
- The history shifts only on cycles where `signal_in_valid` is high.

Feedback and equalization:
- fb = Σ tap[i]·d[i].
- Products are signed full-width, TAP_RESOLUTION+SIGNAL_RESOLUTION bits.
- The sum grows by $clog2(DFE_TAPS)+1 bits.
- eq = signal_in − (fb >>> TAP_FRAC). The shift is arithmetic and floors toward −∞.
- eq saturates to [−2^(SR−1), 2^(SR−1)−1].

Slicing thresholds:
- eq ≥ SEP → 3.
- 0 ≤ eq < SEP → 2.
- −SEP ≤ eq < 0 → 1.
- eq < −SEP → 0.

Symbol-to-level mapping: 0/1/2/3 map to −3S/2, −S/2, +S/2, +3S/2.

Loop closure:
- The decision for sample k feeds back for sample k+1 within a single cycle.
- The subtract, slice and feedback path is combinational from the registered history. No pipelining is allowed inside the loop.

Tap writes:
- A write with `tap_wr_en` high and `tap_wr_addr` < DFE_TAPS updates that tap at the clock edge.
- A write with an address ≥ DFE_TAPS is ignored.

Control FSM, states WARMUP and RUN:
- Reset → WARMUP, with the warm-up counter at 0.
- In WARMUP, the counter increments on each valid sample. When it reaches DFE_TAPS, the FSM moves to RUN.
- RUN is held until reset.
- Outputs are produced in both states, starting from the first valid sample. History entries start at 0.
- Adaptation is permitted only in RUN.

## Timing
- Latency: `symbol_out`, `eq_out` and `symbol_out_valid` register one cycle after the sampled `signal_in_valid`.
- `symbol_out_valid` is low on any cycle following an invalid input cycle. Data outputs hold their last value.
- No backpressure: every valid input produces exactly one valid output.

Reset, on the cycle after `rst` is high:
- `symbol_out`=0, `eq_out`=0, `symbol_out_valid`=0.
- All taps and history entries are 0.
- FSM is in WARMUP; the decimation counter is 0.
- A mid-stream reset discards the in-flight sample.
- Reset overrides tap writes and valid inputs on the same cycle.

Tap write and valid sample on the same cycle:
- The sample uses the old taps.
- The new value is visible to the next sample.

## Configuration
- Macro: `DFE_ADAPT_EN`.
- Defined: sign-sign LMS adaptation.
  - The error is e = eq − level(decision).
  - In RUN, with `adapt_freeze` low, on every 2^ADAPT_DECIM-th valid sample: tap[i] += sign(e)·sign(d[i]) by 1 LSB.
  - Taps saturate at the signed TAP_RESOLUTION limits.
  - sign(0) is treated as 0, giving no update.
  - A simultaneous host write to a tap wins over adaptation for that tap only.
- Undefined:
  - Taps change only through host writes.
  - `adapt_freeze` is unused.
  - The decimation counter is not implemented.

## Test plan
- Slicer levels. After reset with taps 0, inputs 84, 28, −28, −84, 0, 56, −56, −57 → symbols 3, 2, 1, 0, 2, 3, 1, 0. Each output appears one cycle after its input, and `eq_out` equals the input.
- Feedback. Write tap0=32 (0.5), then input 84 followed by 70. The second output has eq=70−42=28 → symbol 2.
- Saturation. Write tap0=−64 (SR=8), then input 84 followed by 127. eq=211 saturates to 127 → symbol 3.
- Valid gaps and ignored write. Run valid, invalid, invalid, valid with tap0=32. The history does not shift on gaps, and `symbol_out_valid` shows the pattern 1,0,0,1. A write to addr 3 with DFE_TAPS=3 leaves `tap_out` unchanged.
- Mid-stream reset. Pulse `rst` for one cycle during traffic. On the next cycle all outputs and taps are 0. The first post-reset sample is sliced with zero history.
- Adaptation (`DFE_ADAPT_EN`, ADAPT_DECIM=0). Drive a PRBS PAM-4 stream with input = a_k + round(0.25·a_{k−1}). After 2000 valid samples, tap0 lies in [14,18] and taps 1 and 2 lie in [−2,2]. Asserting `adapt_freeze` holds `tap_out` constant.
